// File: rtl/pixel_write_packer_if.sv
// rtl/pixel_write_packer_if.sv - SRAM write channel between the pixel packer and memory
interface pixel_write_packer_if #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int SRAMDATA_WIDTH = 32
);
  logic                      ready;
  logic                      request;
  logic                      command_entry;
  logic                      write_enable;
  logic [ADDRESS_WIDTH-1:0]  address;
  logic [SRAMDATA_WIDTH-1:0] data_out;

  modport master (
    input  ready,
    output request, command_entry, write_enable, address, data_out
  );

  modport slave (
    output ready,
    input  request, command_entry, write_enable, address, data_out
  );
endinterface

// File: rtl/pixel_write_packer.sv
// rtl/pixel_write_packer.sv - packs tagged 8-bit pixels into 32-bit words and writes them to SRAM
module pixel_write_packer #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int SRAMDATA_WIDTH = 32,
  parameter int TAG_WIDTH      = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int INVALID_TAG    = 0,
  parameter int DATA_TAG0      = 1,
  parameter int DATA_TAG1      = 2,
  parameter int DATA_END_TAG   = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   reflesh,
  input  logic [8+TAG_WIDTH-1:0] data_in,
  input  logic [31:0]            image_size,
  pixel_write_packer_if.master   wr,
  output logic                   is_end,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [TAG_WIDTH-1:0] T_INV  = TAG_WIDTH'(INVALID_TAG);
  localparam logic [TAG_WIDTH-1:0] T_D0   = TAG_WIDTH'(DATA_TAG0);
  localparam logic [TAG_WIDTH-1:0] T_D1   = TAG_WIDTH'(DATA_TAG1);
  localparam logic [TAG_WIDTH-1:0] T_LAST = TAG_WIDTH'(DATA_END_TAG);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                    state_q, state_d;
  logic                      request_q, request_d;
  logic                      cmd_q, cmd_d;
  logic                      is_end_q, is_end_d;
  logic                      overflow_q, overflow_d;
  logic [ADDRESS_WIDTH-1:0]  address_q, address_d;
  logic [ADDRESS_WIDTH-1:0]  word_addr_q, word_addr_d;
  logic [SRAMDATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [SRAMDATA_WIDTH-1:0] word_q, word_d;
  logic [31:0]               pix_cnt_q, pix_cnt_d;
  logic [1:0]                lane_q, lane_d;
  logic [SRAMDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [SRAMDATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;

  logic [TAG_WIDTH-1:0]      tag;
  logic [7:0]                pixel;
  logic                      is_data;
  logic                      is_last_tag;
  logic                      push, push_ok, pop;
  logic [SRAMDATA_WIDTH-1:0] push_word, assembled;

  assign tag         = data_in[8 +: TAG_WIDTH];
  assign pixel       = data_in[7:0];
  assign is_data     = (tag != T_INV) && ((tag == T_D0) || (tag == T_D1));
  assign is_last_tag = (tag == T_LAST);

  always_comb begin
    state_d     = state_q;
    request_d   = request_q;
    cmd_d       = 1'b0;
    is_end_d    = is_end_q;
    overflow_d  = overflow_q;
    address_d   = address_q;
    word_addr_d = word_addr_q;
    data_out_d  = data_out_q;
    word_d      = word_q;
    pix_cnt_d   = pix_cnt_q;
    lane_d      = lane_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    push        = 1'b0;
    push_word   = '0;
    assembled   = word_q;
    assembled[{lane_q, 3'b000} +: 8] = pixel;
    pop = (count_q != '0) && wr.ready && ((state_q == RUN) || (state_q == FLUSH));

    case (state_q)
      RUN: begin
        // The size limit is tested before acceptance so surplus pixels never land in a word.
        if (is_last_tag || (pix_cnt_q == image_size)) begin
          state_d = FLUSH;
        end else if (is_data) begin
          pix_cnt_d = pix_cnt_q + 32'd1;
          lane_d    = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            push      = 1'b1;
            push_word = assembled;
            word_d    = '0;
          end else begin
            word_d = assembled;
          end
        end
      end
      FLUSH: begin
        if (lane_q != 2'd0) begin
          push      = 1'b1;
          push_word = word_q;
          word_d    = '0;
          lane_d    = 2'd0;
        end else if (count_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        is_end_d  = 1'b1;
        request_d = 1'b0;
      end
      default: ;
    endcase

    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    push_ok = push && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
    if (push && !push_ok) overflow_d = 1'b1;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      cmd_d      = 1'b1;
      data_out_d = mem_q[rd_ptr_q];
      address_d  = word_addr_q;
      if (word_addr_q != {ADDRESS_WIDTH{1'b1}}) word_addr_d = word_addr_q + ADDRESS_WIDTH'(1);
    end

    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop) count_d = count_q - CNT_W'(1);

    if (reflesh) begin
      state_d     = RUN;
      request_d   = 1'b1;
      cmd_d       = 1'b0;
      is_end_d    = 1'b0;
      overflow_d  = 1'b0;
      address_d   = '0;
      word_addr_d = '0;
      data_out_d  = '0;
      word_d      = '0;
      pix_cnt_d   = '0;
      lane_d      = 2'd0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      request_q   <= 1'b0;
      cmd_q       <= 1'b0;
      is_end_q    <= 1'b0;
      overflow_q  <= 1'b0;
      address_q   <= '0;
      word_addr_q <= '0;
      data_out_q  <= '0;
      word_q      <= '0;
      pix_cnt_q   <= '0;
      lane_q      <= 2'd0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      request_q   <= request_d;
      cmd_q       <= cmd_d;
      is_end_q    <= is_end_d;
      overflow_q  <= overflow_d;
      address_q   <= address_d;
      word_addr_q <= word_addr_d;
      data_out_q  <= data_out_d;
      word_q      <= word_d;
      pix_cnt_q   <= pix_cnt_d;
      lane_q      <= lane_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign wr.request       = request_q;
  assign wr.command_entry = cmd_q;
  assign wr.write_enable  = cmd_q;
  assign wr.address       = address_q;
  assign wr.data_out      = data_out_q;
  assign is_end           = is_end_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_pixel_write_packer.sv
// tb/tb_pixel_write_packer.sv - randomized self-checking bench for pixel_write_packer
module tb_pixel_write_packer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          reflesh = 1'b0;
  logic [9:0]    data_in = '0;
  logic [31:0]   image_size = '0;
  logic          is_end;
  logic          overflow;

  pixel_write_packer_if #(.ADDRESS_WIDTH(AW), .SRAMDATA_WIDTH(DW)) wif ();

  pixel_write_packer #(
    .ADDRESS_WIDTH(AW), .SRAMDATA_WIDTH(DW), .TAG_WIDTH(TW), .FIFO_DEPTH(8),
    .INVALID_TAG(0), .DATA_TAG0(1), .DATA_TAG1(2), .DATA_END_TAG(3)
  ) dut (
    .clock(clock), .reset(reset), .reflesh(reflesh), .data_in(data_in),
    .image_size(image_size), .wr(wif), .is_end(is_end), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobes = 0;
  int first_strobe_cyc = -1;
  int last_waited = 0;
  logic [9:0]  stim_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_got(input string name, input int idx, input logic [63:0] exp);
    if (idx < got_q.size()) chk(name, got_q[idx], exp);
    else begin
      total++;
      bad++;
      $display("FAIL %s got=missing exp=%h", name, exp);
    end
  endtask

  function automatic logic [9:0] px(input logic [1:0] t, input logic [7:0] p);
    return {t, p};
  endfunction

  // Reference: walk the pixel list, keep data pixels until the size or an end tag stops the frame.
  function automatic bit build_expected(input int size);
    int cnt = 0;
    int lane = 0;
    int addr = 0;
    bit closed = 0;
    logic [31:0] w = '0;
    exp_q.delete();
    foreach (stim_q[i]) begin
      logic [1:0] tg;
      tg = stim_q[i][9:8];
      if (tg == 2'd3 || cnt == size) begin
        closed = 1;
        break;
      end
      if (tg != 2'd0) begin
        w = w | (32'(stim_q[i][7:0]) << (8 * lane));
        cnt++;
        lane++;
        if (lane == 4) begin
          exp_q.push_back({32'(addr), w});
          addr++;
          w = '0;
          lane = 0;
        end
      end
    end
    if (cnt == size) closed = 1;
    if (closed && lane != 0) exp_q.push_back({32'(addr), w});
    return closed;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      chk("we_equals_ce", 64'(wif.write_enable), 64'(wif.command_entry));
      if (is_end) chk("request_low_when_end", 64'(wif.request), 64'(0));
      if (wif.command_entry === 1'b1) begin
        strobes++;
        if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
        got_q.push_back({wif.address, wif.data_out});
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write got=%h_%h exp=none", wif.address, wif.data_out);
        end else begin
          chk("write_addr_data", {wif.address, wif.data_out}, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_frame(input int size, input int ready_pct, input bit wait_end, input int lat_idx);
    int n_exp;
    int s0;
    int waited;
    int pix_cyc;
    void'(build_expected(size));
    n_exp = exp_q.size();
    got_q.delete();
    s0 = strobes;
    first_strobe_cyc = -1;
    pix_cyc = -1;
    image_size = 32'(size);
    reflesh = 1'b1;
    @(posedge clock);
    #1 reflesh = 1'b0;
    chk("request_after_reflesh", 64'(wif.request), 64'(1));
    chk("is_end_after_reflesh", 64'(is_end), 64'(0));
    foreach (stim_q[i]) begin
      data_in = stim_q[i];
      wif.ready = ($urandom_range(99) < ready_pct);
      if (i == lat_idx) pix_cyc = cyc;
      @(posedge clock);
      #1;
    end
    data_in = '0;
    if (wait_end) begin
      waited = 0;
      while (!is_end && waited < 300) begin
        wif.ready = ($urandom_range(99) < ready_pct);
        @(posedge clock);
        #1;
        waited++;
      end
      last_waited = waited;
      chk("is_end_reached", 64'(is_end), 64'(1));
      repeat (3) @(posedge clock);
      #1;
      chk("strobe_count", 64'(strobes - s0), 64'(n_exp));
      chk("words_pending", 64'(exp_q.size()), 64'(0));
      chk("request_done", 64'(wif.request), 64'(0));
      chk("overflow_done", 64'(overflow), 64'(0));
      chk("is_end_hold", 64'(is_end), 64'(1));
    end
    if (lat_idx >= 0) chk("pix_to_strobe_latency", 64'(first_strobe_cyc - pix_cyc), 64'(2));
  endtask

  initial begin
    int s0;
    wif.ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_request", 64'(wif.request), 64'(0));
    chk("rst_command_entry", 64'(wif.command_entry), 64'(0));
    chk("rst_write_enable", 64'(wif.write_enable), 64'(0));
    chk("rst_address", 64'(wif.address), 64'(0));
    chk("rst_data_out", 64'(wif.data_out), 64'(0));
    chk("rst_is_end", 64'(is_end), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));

    stim_q.delete();
    for (int i = 1; i <= 8; i++) stim_q.push_back(px(2'd1, 8'(i)));
    void'(build_expected(8));
    chk("model_pin_w0", exp_q[0], 64'h00000000_04030201);
    chk("model_pin_w1", exp_q[1], 64'h00000001_08070605);
    run_frame(8, 100, 1, 3);
    chk_got("t1_w0", 0, 64'h00000000_04030201);
    chk_got("t1_w1", 1, 64'h00000001_08070605);

    stim_q.delete();
    for (int i = 1; i <= 6; i++) stim_q.push_back(px(2'd1, 8'(i)));
    run_frame(6, 100, 1, -1);
    chk_got("t2_w1_partial", 1, 64'h00000001_00000605);
    chk("t2_two_writes", 64'(got_q.size()), 64'(2));

    stim_q.delete();
    for (int i = 1; i <= 8; i++) begin
      stim_q.push_back(px(2'd1, 8'(i)));
      stim_q.push_back(px(2'd0, 8'hEE));
    end
    for (int i = 0; i < 3; i++) stim_q.push_back(px(2'd2, 8'h77));
    run_frame(8, 70, 1, -1);
    chk_got("t3_w0", 0, 64'h00000000_04030201);
    chk_got("t3_w1", 1, 64'h00000001_08070605);

    stim_q.delete();
    for (int i = 1; i <= 5; i++) stim_q.push_back(px(2'd2, 8'(i)));
    stim_q.push_back(px(2'd3, 8'h99));
    run_frame(100, 100, 1, -1);
    chk_got("t4_w0", 0, 64'h00000000_04030201);
    chk_got("t4_w1", 1, 64'h00000001_00000005);

    stim_q.delete();
    run_frame(0, 100, 1, -1);
    chk("size0_is_end_edges", 64'(last_waited), 64'(3));
    chk("size0_no_writes", 64'(got_q.size()), 64'(0));

    stim_q.delete();
    for (int i = 0; i < 36; i++) stim_q.push_back(px(2'd1, 8'(i + 1)));
    s0 = strobes;
    run_frame(40, 0, 0, -1);
    while (exp_q.size() > 8) void'(exp_q.pop_back());
    chk("ovf_set", 64'(overflow), 64'(1));
    wif.ready = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    chk("ovf_write_count", 64'(strobes - s0), 64'(8));
    chk("ovf_words_pending", 64'(exp_q.size()), 64'(0));
    chk_got("ovf_last_addr", 7, 64'h00000007_201F1E1D);
    chk("ovf_no_end", 64'(is_end), 64'(0));
    chk("ovf_sticky", 64'(overflow), 64'(1));

    stim_q.delete();
    for (int i = 0; i < 12; i++) stim_q.push_back(px(2'd2, 8'(8'h10 + i)));
    run_frame(100, 0, 0, -1);
    exp_q.delete();
    s0 = strobes;
    #3 reset = 1'b1;
    #1;
    chk("async_rst_request", 64'(wif.request), 64'(0));
    chk("async_rst_ce", 64'(wif.command_entry), 64'(0));
    chk("async_rst_address", 64'(wif.address), 64'(0));
    chk("async_rst_data", 64'(wif.data_out), 64'(0));
    chk("async_rst_is_end", 64'(is_end), 64'(0));
    chk("async_rst_overflow", 64'(overflow), 64'(0));
    wif.ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("no_write_after_reset", 64'(strobes - s0), 64'(0));
    stim_q.delete();
    for (int i = 1; i <= 4; i++) stim_q.push_back(px(2'd1, 8'(8'hA0 + i)));
    run_frame(4, 100, 1, -1);
    chk_got("post_reset_w0", 0, 64'h00000000_A4A3A2A1);

    for (int f = 0; f < 8; f++) begin
      int n;
      int r;
      stim_q.delete();
      n = $urandom_range(0, 40);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 99);
        if (r < 30)      stim_q.push_back(px(2'd0, 8'($urandom)));
        else if (r < 62) stim_q.push_back(px(2'd1, 8'($urandom)));
        else if (r < 95) stim_q.push_back(px(2'd2, 8'($urandom)));
        else             stim_q.push_back(px(2'd3, 8'($urandom)));
      end
      stim_q.push_back(px(2'd3, 8'h00));
      run_frame($urandom_range(0, 30), $urandom_range(40, 100), 1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
